fetch_unit: RTL

Instruction-fetch stage of the single-cycle/pipelined ARM datapath. Owns the program counter and drives the byte address into the instruction ROM. Captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake toward decode. Handles branch redirects (flush plus new target), end-of-program halt, and a sticky fault on bad targets.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_target_calc.sv | 24 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and word-size constants shared by the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;
    localparam int unsigned WORD_SHIFT  = 2;

    function automatic logic [63:0] last_word_addr(
        input logic [63:0] mem_size
    );
        return mem_size - INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: branch target arithmetic and legality check for redirects.
module fetch_target_calc
    import fetch_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = 64'd1024
) (
    input  logic [63:0] base,
    input  logic [63:0] offset,
    output logic [63:0] target,
    output logic        target_ok
);

    logic aligned;
    logic in_range;

    // target + 3 < MEM_SIZE is the same as target <= MEM_SIZE - 4 without wrap
    always_comb begin
        target    = base + (offset << WORD_SHIFT);
        aligned   = (target[1:0] == 2'b00);
        in_range  = (target <= last_word_addr(MEM_SIZE));
        target_ok = aligned && in_range;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, fetch FSM and IF/ID output register with valid/ready.
// Define FETCH_TRACE_EN to print a fetch/redirect trace in simulation.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = 64'd1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_base,
    input  logic [63:0] redirect_offset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [63:0]  out_pc_q, out_pc_d;

    logic [63:0]  target;
    logic         target_ok;
    logic         fire;
    logic         take_redirect;
    logic [63:0]  pc_next;

    fetch_target_calc #(
        .MEM_SIZE (MEM_SIZE)
    ) u_target (
        .base      (redirect_base),
        .offset    (redirect_offset),
        .target    (target),
        .target_ok (target_ok)
    );

    always_comb begin
        fire          = (state_q == RUN) && (!out_valid_q || out_ready);
        take_redirect = redirect_valid && (state_q != FAULT);
        pc_next       = pc_q + INSTR_BYTES;

        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        // a redirect flushes IF/ID even if decode accepts it this cycle
        if (take_redirect) begin
            out_valid_d = 1'b0;
            if (target_ok) begin
                pc_d    = target;
                state_d = RUN;
            end else begin
                state_d = FAULT;
            end
        end else if (fire) begin
            out_instr_d = imem_instr;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            if (pc_next <= last_word_addr(MEM_SIZE)) begin
                pc_d = pc_next;
            end else begin
                state_d = HALT;
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == HALT);
    assign fault     = (state_q == FAULT);

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (take_redirect) begin
                if (target_ok) begin
                    $display("%t fetch redirect target=%h", $time, target);
                end else begin
                    $display("%t fetch redirect FAULT", $time);
                end
            end else if (fire) begin
                $display("%t fetch pc=%h instr=%h", $time, pc_q, imem_instr);
            end
        end
    end
`endif

endmodule
